// File: rtl/signed_addsub_pipe.sv
// Pipelined signed add/subtract with ALU flags and valid/ready handshake.
// Optional clamp-on-overflow when SIGNED_ADDSUB_SAT_EN is defined.
module signed_addsub_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             add_sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             cout
);

    localparam int unsigned SEG = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];

    logic [WIDTH-1:0] a_i   [STAGES];
    logic [WIDTH-1:0] b_i   [STAGES];
    logic [WIDTH-1:0] sum_i [STAGES];
    logic             c_i   [STAGES];
    logic             v_i   [STAGES];

    logic [WIDTH-1:0] sum_n [STAGES];
    logic             c_n   [STAGES];
    logic [SEG:0]     tot;
    logic             c_msb;
    logic             ovf_n;

    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign s         = sum_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

    always_comb begin
        // Stage inputs: stage 0 from the ports, later stages from the previous register.
        a_i[0]   = x;
        b_i[0]   = y ^ {WIDTH{add_sub}};
        sum_i[0] = '0;
        c_i[0]   = cin;
        v_i[0]   = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_i[k]   = a_q[k-1];
            b_i[k]   = b_q[k-1];
            sum_i[k] = sum_q[k-1];
            c_i[k]   = c_q[k-1];
            v_i[k]   = v_q[k-1];
        end
        tot = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            tot = {1'b0, a_i[k][k*SEG +: SEG]} + {1'b0, b_i[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, c_i[k]};
            sum_n[k] = sum_i[k];
            sum_n[k][k*SEG +: SEG] = tot[SEG-1:0];
            c_n[k] = tot[SEG];
        end
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        c_msb = sum_n[STAGES-1][WIDTH-1] ^ a_i[STAGES-1][WIDTH-1] ^ b_i[STAGES-1][WIDTH-1];
        ovf_n = c_msb ^ c_n[STAGES-1];
`ifdef SIGNED_ADDSUB_SAT_EN
        if (ovf_n) begin
            sum_n[STAGES-1] = a_i[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
            end
            overflow <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_i[k];
                b_q[k]   <= b_i[k];
                sum_q[k] <= sum_n[k];
                c_q[k]   <= c_n[k];
                v_q[k]   <= v_i[k];
            end
            overflow <= ovf_n;
            negative <= sum_n[STAGES-1][WIDTH-1];
            zero     <= ~|sum_n[STAGES-1];
        end
    end

endmodule

// File: tb/tb_signed_addsub_pipe.sv
// Bench for signed_addsub_pipe (WIDTH=8, STAGES=2): vector table, random stream,
// backpressure and mid-flight reset, all checked through an expected-result queue.
module tb_signed_addsub_pipe;

    typedef struct packed {
        logic [7:0] s;
        logic       ovf;
        logic       neg;
        logic       zero;
        logic       cout;
    } res_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       as;
        logic       ci;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic       add_sub = 1'b0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] s;
    logic       overflow;
    logic       negative;
    logic       zero;
    logic       cout;

    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];
    res_t mon_e;
    vec_t vecs[8];

    signed_addsub_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .add_sub(add_sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .s(s),
        .overflow(overflow), .negative(negative), .zero(zero), .cout(cout)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic as, input logic ci);
        logic [7:0] bb;
        logic [8:0] t;
        logic [7:0] lo;
        res_t       r;
        bb = as ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {8'h00, ci};
        lo = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'h00, ci};
        r.s    = t[7:0];
        r.ovf  = lo[7] ^ t[8];
`ifdef SIGNED_ADDSUB_SAT_EN
        if (r.ovf) r.s = a[7] ? 8'h80 : 8'h7F;
`endif
        r.neg  = r.s[7];
        r.zero = (r.s == 8'h00);
        r.cout = t[8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One clock: drive inputs after the edge, record the beat if it will be accepted.
    task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic as, input logic ci, input logic ordy,
                         input res_t e, output logic acc);
        @(posedge clk);
        #1;
        in_valid = iv; x = a; y = b; add_sub = as; cin = ci; out_ready = ordy;
        #1;
        chk("in_ready_rule", {15'h0, in_ready}, {15'h0, (!out_valid || out_ready)});
        acc = iv && in_ready;
        if (acc) exp_q.push_back(e);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ordy, '0, acc);
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) idle(1'b1);
        chk("drain_empty", 16'(exp_q.size()), 16'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got s=%h with no beat outstanding", s);
            end else begin
                mon_e = exp_q.pop_front();
                if ({s, overflow, negative, zero, cout} !== mon_e) begin
                    fails++;
                    $display("FAIL result: got s=%h ovf=%b neg=%b z=%b c=%b, expected s=%h ovf=%b neg=%b z=%b c=%b",
                             s, overflow, negative, zero, cout,
                             mon_e.s, mon_e.ovf, mon_e.neg, mon_e.zero, mon_e.cout);
                end
            end
        end
    end

    initial begin
        logic       acc;
        logic [7:0] held;
        logic       a_v, a_as, a_ci, a_or;
        logic [7:0] a_x, a_y;
        int         sent;
        int         bi;

`ifdef SIGNED_ADDSUB_SAT_EN
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 1'b1, '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1}};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1}};
        vecs[7] = '{8'h40, 8'h3F, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b0}};
`else
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 1'b1, '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1}};
        vecs[7] = '{8'h40, 8'h3F, 1'b0, 1'b1, '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0}};
`endif
        vecs[1] = '{8'h05, 8'h05, 1'b1, 1'b1, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1}};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 1'b1, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1}};
        vecs[4] = '{8'h0F, 8'h01, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{8'h00, 8'h01, 1'b1, 1'b1, '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0}};

        #12;
        chk("reset_out_valid", {15'h0, out_valid}, 16'h0);
        chk("reset_flags", {8'h00, s, overflow, negative, zero, cout}, 16'h0);
        chk("reset_in_ready", {15'h0, in_ready}, 16'h1);
        rst_n = 1'b1;

        // Directed vectors, back to back.
        foreach (vecs[i]) begin
            acc = 1'b0;
            for (int t = 0; t < 10 && !acc; t++)
                cycle(1'b1, vecs[i].x, vecs[i].y, vecs[i].as, vecs[i].ci, 1'b1, vecs[i].exp, acc);
            if (!acc) chk("vector_accept", 16'h0, 16'h1);
        end
        drain();

        // Random stream with bubbles and random backpressure.
        sent = 0;
        for (int c = 0; c < 300 && sent < 30; c++) begin
            a_v  = ($urandom_range(3) != 0);
            a_x  = 8'($urandom);
            a_y  = 8'($urandom);
            a_as = 1'($urandom);
            a_ci = 1'($urandom);
            a_or = ($urandom_range(2) != 0);
            cycle(a_v, a_x, a_y, a_as, a_ci, a_or, model(a_x, a_y, a_as, a_ci), acc);
            if (acc) sent++;
        end
        chk("random_sent", 16'(sent), 16'd30);
        drain();

        // Six beats with a three-cycle stall in the middle.
        bi = 0;
        held = '0;
        for (int k = 0; k < 30 && (bi < 6 || exp_q.size() != 0); k++) begin
            a_x = 8'(8'h11 * (bi + 1));
            a_y = 8'(8'h07 + bi);
            a_or = !(k >= 3 && k < 6);
            cycle(bi < 6, a_x, a_y, bi[0], 1'b1, a_or, model(a_x, a_y, bi[0], 1'b1), acc);
            if (acc) bi++;
            if (k == 3) held = s;
            if (k >= 3 && k < 6) begin
                chk("stall_in_ready", {15'h0, in_ready}, 16'h0);
                chk("stall_out_valid", {15'h0, out_valid}, 16'h1);
                chk("stall_s_held", {8'h00, s}, {8'h00, held});
            end
        end
        chk("stall_all_sent", 16'(bi), 16'd6);
        drain();

        // Reset with two beats in flight.
        cycle(1'b1, 8'h21, 8'h12, 1'b0, 1'b0, 1'b0, model(8'h21, 8'h12, 1'b0, 1'b0), acc);
        cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, model(8'h33, 8'h44, 1'b0, 1'b0), acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {15'h0, out_valid}, 16'h0);
        chk("midreset_s", {8'h00, s, overflow, negative, zero, cout}, 16'h0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            chk("post_reset_no_stale", {15'h0, out_valid}, 16'h0);
        end
        cycle(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, vecs[0].exp, acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
